// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment encodings, frame constants and decoder state type.
package seg_pkg;
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [3:0] DIGIT_INVALID = 4'hF;
  localparam int NUM_DIGITS = 6;
  typedef enum logic [1:0] {HUNT, COLLECT, PUBLISH} state_t;
  function automatic logic has_invalid(input logic [4*NUM_DIGITS-1:0] f);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) bad |= f[4*i +: 4] == DIGIT_INVALID;
    return bad;
  endfunction
endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational seven-segment to BCD decode with a valid flag.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       valid
);
  always_comb begin
    case (seg)
      SEG_0: bcd = 4'd0;
      SEG_1: bcd = 4'd1;
      SEG_2: bcd = 4'd2;
      SEG_3: bcd = 4'd3;
      SEG_4: bcd = 4'd4;
      SEG_5: bcd = 4'd5;
      SEG_6: bcd = 4'd6;
      SEG_7: bcd = 4'd7;
      SEG_8: bcd = 4'd8;
      SEG_9: bcd = 4'd9;
      default: bcd = DIGIT_INVALID;
    endcase
  end
  assign valid = bcd != DIGIT_INVALID;
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed six-digit seven-segment bus and
// rebuilds the displayed HH:MM:SS as BCD frames.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        MHz,
  input  logic        Reset,
  input  logic [2:0]  DE,
  input  logic [6:0]  seg,
  output logic [23:0] digits,
  output logic        frame_valid,
  output logic        seq_err,
  output logic        seg_err
);
  logic [9:0] sync_q [SYNC_STAGES];
  logic [9:0] pair, prev_q;
  logic [7:0] cnt;
  logic armed, changed, cap;
  logic [2:0] sde, exp_q, exp_n;
  logic [6:0] sseg;
  logic [3:0] dec;
  logic dec_ok, wr, abort, pub, frame_ok;
  logic [23:0] stg, frame;
  state_t state, state_n;
  assign pair = sync_q[SYNC_STAGES-1];
  assign sde = pair[9:7];
  assign sseg = pair[6:0];
  assign changed = pair != prev_q;
  assign cap = !changed && armed && cnt == 8'(SETTLE - 1);
  seg7_to_bcd u_dec (.seg(sseg), .bcd(dec), .valid(dec_ok));
  // The S2 digit is still in flight on the decoder, so the frame is judged with it spliced in.
  assign frame = {stg[23:4], dec};
  assign frame_ok = !has_invalid(frame);
  always_ff @(posedge MHz or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      cnt <= '0;
      armed <= 1'b1;
    end else begin
      sync_q[0] <= {DE, seg};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= pair;
      cnt <= changed ? 8'd0 : (cnt == 8'hFF ? cnt : cnt + 8'd1);
      armed <= changed ? 1'b1 : (cap ? 1'b0 : armed);
    end
  end
  always_comb begin
    state_n = state;
    exp_n = exp_q;
    wr = 1'b0;
    abort = 1'b0;
    pub = 1'b0;
    case (state)
      HUNT: if (cap && sde == 3'd0) begin
        wr = 1'b1;
        exp_n = 3'd1;
        state_n = COLLECT;
      end
      COLLECT: if (cap) begin
        if (sde == exp_q) begin
          wr = 1'b1;
          exp_n = exp_q + 3'd1;
          pub = exp_q == 3'd5;
          state_n = exp_q == 3'd5 ? PUBLISH : COLLECT;
        end else if (sde == exp_q - 3'd1) begin
          wr = 1'b1;
        end else begin
          abort = 1'b1;
          wr = sde == 3'd0;
          exp_n = 3'd1;
          state_n = sde == 3'd0 ? COLLECT : HUNT;
        end
      end
      default: state_n = HUNT;
    endcase
  end
  always_ff @(posedge MHz or posedge Reset) begin
    if (Reset) begin
      state <= HUNT;
      exp_q <= '0;
      stg <= '0;
      digits <= '0;
      frame_valid <= 1'b0;
      seq_err <= 1'b0;
      seg_err <= 1'b0;
    end else begin
      state <= state_n;
      exp_q <= exp_n;
      for (int d = 0; d < NUM_DIGITS; d++)
        if (wr && sde == 3'(d)) stg[4*(NUM_DIGITS-1-d) +: 4] <= dec;
      digits <= pub && frame_ok ? frame : digits;
      frame_valid <= pub && frame_ok;
      seq_err <= abort || (pub && !frame_ok);
      seg_err <= seg_err || (cap && !dec_ok);
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed-vector bench for the scan decoder with hand-computed results.
module tb_seg_scan_decoder;
  logic MHz = 1'b0;
  logic Reset = 1'b1;
  logic [2:0] DE = 3'd7;
  logic [6:0] seg = 7'b1111111;
  logic [23:0] digits;
  logic frame_valid, seq_err, seg_err;
  int n_checks = 0, n_fail = 0;
  int fv_cnt = 0, sq_cnt = 0;
  int fv0, sq0;

  seg_scan_decoder #(.SETTLE(4), .SYNC_STAGES(2)) dut (
    .MHz(MHz), .Reset(Reset), .DE(DE), .seg(seg),
    .digits(digits), .frame_valid(frame_valid), .seq_err(seq_err), .seg_err(seg_err)
  );

  always #5 MHz = ~MHz;

  always @(negedge MHz) if (!Reset) begin
    fv_cnt += int'(frame_valid);
    sq_cnt += int'(seq_err);
  end

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  task automatic hold(input logic [2:0] d, input logic [6:0] s, input int n);
    DE = d;
    seg = s;
    repeat (n) @(posedge MHz);
    #1;
  endtask

  task automatic idle(input int n);
    hold(3'd7, 7'b1111111, n);
  endtask

  task automatic scan(input logic [23:0] v, input int n);
    for (int i = 0; i < 6; i++) hold(3'(i), enc(v[4*(5-i) +: 4]), n);
  endtask

  task automatic mark;
    fv0 = fv_cnt;
    sq0 = sq_cnt;
  endtask

  task automatic events(input string tag, input int fv, input int sq);
    check({tag, " frame_valid pulses"}, 24'(fv_cnt - fv0), 24'(fv));
    check({tag, " seq_err pulses"}, 24'(sq_cnt - sq0), 24'(sq));
  endtask

  initial begin
    #12;
    check("reset digits", digits, 24'h0);
    check("reset flags", {21'd0, frame_valid, seq_err, seg_err}, 24'h0);
    @(posedge MHz);
    #1 Reset = 1'b0;
    idle(6);

    mark();
    scan(24'h115959, 8);
    idle(10);
    events("clean", 1, 0);
    check("clean digits", digits, 24'h115959);
    check("clean seg_err", {23'd0, seg_err}, 24'h0);

    mark();
    hold(3'd0, enc(4'd1), 8);
    for (int i = 0; i < 6; i++) hold(3'd1, i % 2 ? enc(4'd2) : enc(4'd3), 1);
    hold(3'd1, enc(4'd5), 6);
    hold(3'd1, enc(4'd1), 5);
    for (int i = 2; i < 6; i++) hold(3'(i), enc(4'(i)), 8);
    idle(10);
    events("glitch", 1, 0);
    check("glitch digits", digits, 24'h112345);

    mark();
    hold(3'd0, enc(4'd7), 8);
    hold(3'd1, enc(4'd7), 8);
    hold(3'd3, enc(4'd7), 8);
    idle(6);
    events("order", 0, 1);
    check("order digits kept", digits, 24'h112345);
    mark();
    scan(24'h235900, 8);
    idle(10);
    events("after order", 1, 0);
    check("after order digits", digits, 24'h235900);

    mark();
    hold(3'd0, enc(4'd1), 8);
    hold(3'd1, enc(4'd2), 8);
    hold(3'd6, enc(4'd8), 8);
    idle(6);
    events("de6", 0, 1);

    mark();
    scan(24'h123456, 3);
    idle(10);
    events("short", 0, 0);
    check("short digits", digits, 24'h235900);
    check("short seg_err", {23'd0, seg_err}, 24'h0);

    mark();
    hold(3'd0, enc(4'd1), 8);
    hold(3'd1, enc(4'd2), 8);
    hold(3'd2, 7'b0000001, 8);
    for (int i = 3; i < 6; i++) hold(3'(i), enc(4'd4), 8);
    idle(10);
    events("badseg", 0, 1);
    check("badseg sticky", {23'd0, seg_err}, 24'h1);
    check("badseg digits kept", digits, 24'h235900);

    hold(3'd0, enc(4'd1), 8);
    hold(3'd1, enc(4'd2), 8);
    DE = 3'd2;
    seg = enc(4'd3);
    @(posedge MHz);
    #3 Reset = 1'b1;
    #1;
    check("async digits", digits, 24'h0);
    check("async flags", {21'd0, frame_valid, seq_err, seg_err}, 24'h0);
    DE = 3'd7;
    seg = 7'b1111111;
    @(posedge MHz);
    #1 Reset = 1'b0;
    idle(6);
    mark();
    scan(24'h000000, 8);
    idle(10);
    events("post reset", 1, 0);
    check("post reset digits", digits, 24'h0);
    check("post reset seg_err", {23'd0, seg_err}, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the stopwatch display driver: samples a multiplexed 6-digit seven-segment bus (digit select DE plus segment lines seg) and reconstructs the displayed HH:MM:SS as BCD.
- Sits in the verification/readback path, e.g. board self-check or logic-analyser capture.
- Publishes a complete six-digit frame only after digits 0..5 are captured in scan order.
- Flags illegal segment patterns and illegal or out-of-order digit selects.

Parameters:
- SETTLE, 4, consecutive MHz cycles the synchronised (DE, seg) pair must hold unchanged before a digit is captured; legal range 1..255.
- SYNC_STAGES, 2, flip-flop stages on the DE and seg inputs; legal range 2..3.

Ports:
- MHz  input  1  system clock; all logic is on posedge.
- Reset  input  1  asynchronous, active-high reset.
- DE  input  3  digit select from the display driver; 0=H1, 1=H2, 2=M1, 3=M2, 4=S1, 5=S2; 6 and 7 are illegal.
- seg  input  7  active-high segments, bit6=a … bit0=g.
- digits  output  24  last published frame, 4-bit BCD per digit; [23:20]=H1, [19:16]=H2, [15:12]=M1, [11:8]=M2, [7:4]=S1, [3:0]=S2.
- frame_valid  output  1  one-cycle pulse in the cycle digits updates.
- seq_err  output  1  one-cycle pulse when a frame is aborted.
- seg_err  output  1  sticky; set by an undecodable pattern; cleared only by Reset.

Behaviour:
- Reset (async, active-high) clears:
  - digits=0, frame_valid=0, seq_err=0, seg_err=0;
  - staging registers=0, stability counter=0, sync chains=0, armed=1;
  - state=HUNT.
- Synchronisation: DE and seg pass through SYNC_STAGES flops. sDE/sseg are the outputs; pDE/pseg are their one-cycle-delayed copies.
- Stability counter (8-bit):
  - if (sDE,sseg) != (pDE,pseg): counter=0 and armed=1;
  - else counter increments, saturating at 255.
- Capture event: fires in the cycle where counter==SETTLE-1, armed=1 and the pair is unchanged; armed then clears. At most one capture per stable dwell.
- If seg changes within the same DE dwell, the detector re-arms and the same index is captured again. The last stable value wins; this is not a sequence error.
- Decode table (any other pattern → value 4'hF and seg_err set):
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4
  - 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9
- State machine, with exp = expected next index (0..5):
  - HUNT:
    - capture with sDE==0 → store staging[0], exp=1, go COLLECT;
    - any other capture → ignored, no error.
  - COLLECT:
    - capture with sDE==exp → store staging[exp], exp+1;
    - if exp was 5 → go PUBLISH;
    - capture with sDE==exp-1 (re-capture) → overwrite that staging slot, no error;
    - capture with any other sDE, including 6 or 7 → seq_err pulse, go HUNT. If sDE==0, the abort and the new start happen in the same cycle: staging[0] stored, exp=1, state COLLECT.
  - PUBLISH: lasts one cycle.
    - If any staged digit is 4'hF (decode failure): frame discarded, seq_err pulse, frame_valid=0, go HUNT.
    - Otherwise digits ← staging and frame_valid=1 in that same cycle, go HUNT.
- Latency:
  - frame_valid is registered one cycle after the S2 capture;
  - the S2 capture is SYNC_STAGES+SETTLE cycles after the S2 dwell begins at the pins.
- A capture event during the PUBLISH cycle is lost; the next frame resumes via HUNT.
- No range check on the value: H1>1 or M1>5 publish as-is. The block decodes the display; it does not validate the time.
- Reset mid-frame: staging discarded; digits returns to 0.

Decomposition:
- Shared package seg_pkg holds:
  - the ten segment constants (SEG_0..SEG_9, same encoding as the display driver);
  - DIGIT_INVALID=4'hF;
  - NUM_DIGITS=6;
  - state enum {HUNT, COLLECT, PUBLISH}.
- One natural sub-module: seg7_to_bcd, a purely combinational 7-bit to 4-bit decode plus valid flag. The display driver can reuse the constants for its encoder.

Test Plan:
- Clean scan: SETTLE=4, each DE 0..5 held 8 cycles showing 1,1,5,9,5,9 → frame_valid single pulse, digits=24'h115959, seq_err=0, seg_err=0.
- Glitch rejection: seg toggles every cycle within a DE dwell, then settles on 1011011 for 6 cycles → exactly one capture of value 5; mid-dwell change to 0110000, stable 5 cycles → published digit is 1, no seq_err.
- Out-of-order: DE sequence 0,1,3 → seq_err pulse on the DE=3 capture, no frame_valid, digits unchanged; following clean scan 0..5 publishes normally.
- Illegal DE/pattern: DE=6 during COLLECT → seq_err. In a separate run, seg=0000001 on DE=2 → seg_err stays 1, frame discarded, digits unchanged.
- Short dwell: DE held SETTLE-1=3 cycles per digit → no captures, no frame_valid, no errors; remains in HUNT.
- Async reset: assert Reset mid-frame between clock edges → digits=0 and all flags=0 immediately; after release, the next full scan 0,0,0,0,0,0 publishes digits=24'h000000 with frame_valid.
